// File: rtl/pomdp_episode_ctrl.sv
// Run-level sequencer for the POMDP sim: reseeds, launches and counts steps per episode,
// accumulates the final episode reward, and guards each step with a watchdog.
module pomdp_episode_ctrl #(
  parameter int HOR_W   = 8,
  parameter int EP_W    = 8,
  parameter int ACC_W   = 48,
  parameter int TIMEOUT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [HOR_W-1:0]  cfg_horizon,
  input  logic [EP_W-1:0]   cfg_episodes,
  input  logic [15:0]       cfg_seed0,
  input  logic [15:0]       cfg_seed1,
  output logic              sim_rst_n,
  output logic              sim_en,
  output logic [15:0]       sim_seed0,
  output logic [15:0]       sim_seed1,
  input  logic              sim_step_done,
  input  logic [31:0]       sim_reward,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err_timeout,
  output logic [EP_W-1:0]   episode_idx,
  output logic [HOR_W-1:0]  step_idx,
  output logic [ACC_W-1:0]  total_reward
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_LAUNCH, S_RUN, S_SETTLE, S_ACCUM, S_DONE
  } state_t;

  state_t            state;
  logic [HOR_W-1:0]  hor_q;
  logic [EP_W-1:0]   eps_q;
  logic [15:0]       seed0_q, seed1_q;
  logic [WD_W-1:0]   wd;
  logic [SC_W-1:0]   settle_cnt;
  logic              timeout_hit, abort_req, last_ep;

  // 0x0000 locks an LFSR, so a wrapped seed of zero is bumped to one
  function automatic logic [15:0] seed_of(input logic [15:0] base, input logic [EP_W-1:0] idx);
    logic [15:0] s;
    s = base + 16'(idx);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // wd holds cycles elapsed since launch/last step, counting the current one
  assign timeout_hit = (state == S_RUN) && !sim_step_done && (wd == WD_W'(TIMEOUT - 1));
  assign abort_req   = (state != S_IDLE) && (cfg_abort || timeout_hit);
  assign last_ep     = ({1'b0, episode_idx} + 1'b1) == {1'b0, eps_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hor_q        <= '0;
      eps_q        <= '0;
      seed0_q      <= '0;
      seed1_q      <= '0;
      wd           <= '0;
      settle_cnt   <= '0;
      sim_rst_n    <= 1'b1;
      sim_en       <= 1'b0;
      sim_seed0    <= 16'h0001;
      sim_seed1    <= 16'h0001;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      err_timeout  <= 1'b0;
      episode_idx  <= '0;
      step_idx     <= '0;
      total_reward <= '0;
    end else begin
      sim_en    <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      sim_rst_n <= 1'b1;
      if (abort_req) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        aborted   <= 1'b1;
        sim_rst_n <= 1'b0;
        if (timeout_hit) err_timeout <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (cfg_start) begin
            hor_q        <= cfg_horizon;
            eps_q        <= cfg_episodes;
            seed0_q      <= cfg_seed0;
            seed1_q      <= cfg_seed1;
            err_timeout  <= 1'b0;
            total_reward <= '0;
            episode_idx  <= '0;
            step_idx     <= '0;
            busy         <= 1'b1;
            if (cfg_horizon == '0 || cfg_episodes == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_SEED;
              sim_rst_n <= 1'b0;
              sim_seed0 <= seed_of(cfg_seed0, '0);
              sim_seed1 <= seed_of(cfg_seed1, '0);
            end
          end
          S_SEED: begin
            state    <= S_LAUNCH;
            sim_en   <= 1'b1;
            step_idx <= '0;
          end
          S_LAUNCH: begin
            state <= S_RUN;
            wd    <= WD_W'(1);
          end
          S_RUN: begin
            if (sim_step_done) begin
              step_idx <= step_idx + 1'b1;
              wd       <= WD_W'(1);
              if (step_idx + 1'b1 == hor_q) begin
                state      <= S_SETTLE;
                settle_cnt <= '0;
              end
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == SC_W'(SETTLE - 1)) state <= S_ACCUM;
            else settle_cnt <= settle_cnt + 1'b1;
          end
          S_ACCUM: begin
            total_reward <= total_reward + ACC_W'(sim_reward);
            if (last_ep) begin
              state <= S_DONE;
            end else begin
              state       <= S_SEED;
              episode_idx <= episode_idx + 1'b1;
              sim_rst_n   <= 1'b0;
              sim_seed0   <= seed_of(seed0_q, episode_idx + 1'b1);
              sim_seed1   <= seed_of(seed1_q, episode_idx + 1'b1);
            end
          end
          S_DONE: begin
            // done and the datapath park land together as the FSM returns to IDLE
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sim_rst_n <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pomdp_episode_ctrl.sv
// Scoreboard bench for pomdp_episode_ctrl: stimulus queues expected seeds and run outcomes,
// a negedge monitor pops and compares on each sim_en / done / aborted pulse.
module tb_pomdp_episode_ctrl;
  localparam int HOR_W = 8, EP_W = 8, ACC_W = 48, TO = 16, SET = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 0, cfg_abort = 0, sim_step_done = 0;
  logic [HOR_W-1:0] cfg_horizon = '0;
  logic [EP_W-1:0]  cfg_episodes = '0;
  logic [15:0]      cfg_seed0 = '0, cfg_seed1 = '0;
  logic [31:0]      sim_reward = '0;
  logic sim_rst_n, sim_en, busy, done, aborted, err_timeout;
  logic [15:0] sim_seed0, sim_seed1;
  logic [EP_W-1:0]  episode_idx;
  logic [HOR_W-1:0] step_idx;
  logic [ACC_W-1:0] total_reward;

  pomdp_episode_ctrl #(.HOR_W(HOR_W), .EP_W(EP_W), .ACC_W(ACC_W), .TIMEOUT(TO), .SETTLE(SET)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_horizon(cfg_horizon), .cfg_episodes(cfg_episodes), .cfg_seed0(cfg_seed0), .cfg_seed1(cfg_seed1),
    .sim_rst_n(sim_rst_n), .sim_en(sim_en), .sim_seed0(sim_seed0), .sim_seed1(sim_seed1),
    .sim_step_done(sim_step_done), .sim_reward(sim_reward), .busy(busy), .done(done), .aborted(aborted),
    .err_timeout(err_timeout), .episode_idx(episode_idx), .step_idx(step_idx), .total_reward(total_reward));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_done;
    logic [ACC_W-1:0] total;
    logic [EP_W-1:0]  ep;
    logic [HOR_W-1:0] step;
    bit               err;
  } end_t;

  logic [31:0] exp_seed_q[$];
  end_t        exp_end_q[$];
  logic [31:0] rewards[8];
  int checks = 0, passed = 0, done_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference seed rule: (base + episode) mod 2^16, zero replaced by one
  function automatic logic [15:0] mseed(logic [15:0] b, int e);
    int s;
    s = (int'(b) + e) % 65536;
    return (s == 0) ? 16'h0001 : 16'(s);
  endfunction

  function automatic void push_seed(logic [15:0] s0, logic [15:0] s1, int e);
    exp_seed_q.push_back({mseed(s0, e), mseed(s1, e)});
  endfunction

  function automatic void push_end(bit d, logic [ACC_W-1:0] t, int ep, int st, bit err);
    end_t x;
    x.is_done = d; x.total = t; x.ep = EP_W'(ep); x.step = HOR_W'(st); x.err = err;
    exp_end_q.push_back(x);
  endfunction

  // Monitor
  logic        prev_rst = 1'b1;
  logic [31:0] m_seed;
  end_t        m_end;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sim_en) begin
        if (exp_seed_q.size() == 0) chk("unexpected_sim_en", 1, 0);
        else begin
          m_seed = exp_seed_q.pop_front();
          chk("seed0", sim_seed0, m_seed[31:16]);
          chk("seed1", sim_seed1, m_seed[15:0]);
          chk("launch_rst_released", sim_rst_n, 1);
          chk("seed_phase_rst_low", prev_rst, 0);
        end
      end
      if (done || aborted) begin
        if (done) done_cnt++;
        if (exp_end_q.size() == 0) chk("unexpected_end_pulse", {done, aborted}, 0);
        else begin
          m_end = exp_end_q.pop_front();
          chk("end_kind", {done, aborted}, m_end.is_done ? 2'b10 : 2'b01);
          chk("end_total", total_reward, m_end.total);
          chk("end_episode_idx", episode_idx, m_end.ep);
          chk("end_step_idx", step_idx, m_end.step);
          chk("end_err_timeout", err_timeout, m_end.err);
          chk("end_park_rst", sim_rst_n, 0);
          chk("end_busy", busy, 0);
        end
      end
    end
    prev_rst <= sim_rst_n;
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(int h, int e, logic [15:0] s0, logic [15:0] s1);
    cfg_horizon = HOR_W'(h); cfg_episodes = EP_W'(e); cfg_seed0 = s0; cfg_seed1 = s1;
    cfg_start = 1; tick; cfg_start = 0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (sim_en) begin ok = 1; break; end
      tick;
    end
    if (!ok) chk("wait_sim_en_expired", 0, 1);
  endtask

  task automatic wait_idle(int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1; break; end
      tick;
    end
    if (!ok) chk("wait_idle_expired", 0, 1);
  endtask

  // Issue n step pulses with random gaps; returns the cycle of the last pulse
  task automatic do_steps(int n, output int last_cyc);
    last_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      tick($urandom_range(0, 3));
      sim_step_done = 1; last_cyc = cyc; tick; sim_step_done = 0;
    end
  endtask

  task automatic full_run(int h, int e, logic [15:0] s0, logic [15:0] s1);
    logic [ACC_W-1:0] tot = '0;
    bit ok; int lc;
    if (h > 0 && e > 0) begin
      for (int i = 0; i < e; i++) begin push_seed(s0, s1, i); tot += ACC_W'(rewards[i]); end
      push_end(1, tot, e - 1, h, 0);
    end else push_end(1, '0, 0, 0, 0);
    start_run(h, e, s0, s1);
    if (h > 0 && e > 0)
      for (int i = 0; i < e; i++) begin
        wait_en(ok);
        if (!ok) return;
        sim_reward = rewards[i]; tick; do_steps(h, lc);
      end
    wait_idle(60);
    tick(2);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0); chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_sim_rst_n"}, sim_rst_n, 1); chk({tag, "_sim_en"}, sim_en, 0);
    chk({tag, "_seed0"}, sim_seed0, 16'h0001); chk({tag, "_seed1"}, sim_seed1, 16'h0001);
    chk({tag, "_ep"}, episode_idx, 0); chk({tag, "_step"}, step_idx, 0);
    chk({tag, "_total"}, total_reward, 0);
  endtask

  initial begin
    bit ok; int lc, t0, dc;
    tick(2);
    chk_reset_vals("reset");
    rst_n = 1; tick(2);

    // Directed run: 3 episodes of 4 steps, rewards 10/20/30
    rewards[0] = 10; rewards[1] = 20; rewards[2] = 30;
    full_run(4, 3, 16'h1234, 16'hABCD);
    chk("run1_aborted_low", aborted, 0);

    // Seed wrap
    rewards[0] = 5; rewards[1] = 6;
    full_run(1, 2, 16'hFFFF, 16'h0000);

    // Zero config: horizon 0
    push_end(1, '0, 0, 0, 0);
    start_run(0, 5, 16'h1111, 16'h2222);
    chk("zero_busy_c1", busy, 1); chk("zero_done_c1", done, 0);
    tick; chk("zero_done_c2", done, 1); chk("zero_busy_c2", busy, 0);
    tick; chk("zero_busy_c3", busy, 0);

    // Watchdog timeout after two steps
    push_seed(16'h0042, 16'h0043, 0);
    push_end(0, '0, 0, 2, 1);
    start_run(4, 1, 16'h0042, 16'h0043);
    wait_en(ok); sim_reward = 99; tick; do_steps(2, lc);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (aborted) begin ok = 1; break; end
      tick;
    end
    chk("timeout_seen", ok, 1);
    chk("timeout_latency", cyc - lc, TO);
    chk("timeout_err_set", err_timeout, 1);
    tick;
    chk("timeout_rst_release", sim_rst_n, 1); chk("timeout_idle", busy, 0);
    chk("timeout_err_sticky", err_timeout, 1); chk("timeout_step_idx", step_idx, 2);
    tick(2);

    // Abort collides with final step of episode 1
    rewards[0] = 7; rewards[1] = $urandom;
    push_seed(16'h0100, 16'h0200, 0); push_seed(16'h0100, 16'h0200, 1);
    push_end(0, 48'd7, 1, 2, 0);
    dc = done_cnt;
    start_run(3, 3, 16'h0100, 16'h0200);
    wait_en(ok); sim_reward = rewards[0]; tick; do_steps(3, lc);
    wait_en(ok); sim_reward = rewards[1]; tick; do_steps(2, lc);
    tick($urandom_range(0, 3));
    cfg_abort = 1; sim_step_done = 1; tick; cfg_abort = 0; sim_step_done = 0;
    wait_idle(20); tick(10);
    chk("collision_no_done", done_cnt, dc);

    // Start while busy must not relatch horizon
    rewards[0] = $urandom;
    push_seed(16'h7777, 16'h8888, 0);
    push_end(1, ACC_W'(rewards[0]), 0, 3, 0);
    start_run(3, 1, 16'h7777, 16'h8888);
    wait_en(ok); sim_reward = rewards[0]; tick; do_steps(1, lc);
    cfg_horizon = 9; cfg_start = 1; tick; cfg_start = 0;
    do_steps(2, lc);
    wait_idle(40); tick(2);

    // Async reset during SETTLE
    push_seed(16'h0505, 16'h0606, 0);
    start_run(2, 2, 16'h0505, 16'h0606);
    wait_en(ok); sim_reward = 123; tick; do_steps(2, lc);
    rst_n = 0; #1;
    chk_reset_vals("async");
    tick; rst_n = 1; tick;

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      int h, e;
      logic [15:0] s0;
      h = $urandom_range(1, 6); e = $urandom_range(1, 4);
      s0 = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - $urandom_range(0, 2)) : 16'($urandom);
      for (int i = 0; i < e; i++) rewards[i] = $urandom;
      full_run(h, e, s0, 16'($urandom));
    end

    chk("seed_queue_drained", exp_seed_q.size(), 0);
    chk("end_queue_drained", exp_end_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end
endmodule
